// File: rtl/ls74163_if.sv
// rtl/ls74163_if.sv - control, data and status bundle for one ls74163 counter slice
interface ls74163_if #(
    parameter int WIDTH = 4
);
    logic             clr_n;
    logic             load_n;
    logic             enp;
    logic             ent;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             rco;

    // Side that drives the controls, such as a sequencer or the previous slice.
    modport master (
        output clr_n,
        output load_n,
        output enp,
        output ent,
        output d,
        input  q,
        input  rco
    );

    // The counter itself.
    modport slave (
        input  clr_n,
        input  load_n,
        input  enp,
        input  ent,
        input  d,
        output q,
        output rco
    );
endinterface

// File: rtl/ls74163.sv
// rtl/ls74163.sv - presettable binary counter with synchronous clear and ripple carry out
module ls74163 #(
    parameter int WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    ls74163_if.slave    bus
);
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next count: clear beats load, load beats count, and counting needs both enables.
    always_comb begin
        q_d = q_q;
        if (!bus.clr_n) begin
            q_d = '0;
        end else if (!bus.load_n) begin
            q_d = bus.d;
        end else if (bus.enp && bus.ent) begin
            q_d = q_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Count register; reset clears it immediately, without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign bus.q   = q_q;
    // The carry depends only on ent and the count, so a chain of slices ripples
    // through ent without involving enp.
    assign bus.rco = bus.ent & (&q_q);
endmodule

// File: tb/tb_ls74163.sv
// tb/tb_ls74163.sv - self-checking bench for ls74163 with a behavioural reference model
module tb_ls74163;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   model;
    int   cmodel;

    ls74163_if #(.WIDTH(4)) u_if ();
    ls74163_if #(.WIDTH(4)) lo_if ();
    ls74163_if #(.WIDTH(4)) hi_if ();

    ls74163 #(.WIDTH(4)) u_dut (.clk(clk), .rst(rst), .bus(u_if.slave));
    ls74163 #(.WIDTH(4)) u_lo  (.clk(clk), .rst(rst), .bus(lo_if.slave));
    ls74163 #(.WIDTH(4)) u_hi  (.clk(clk), .rst(rst), .bus(hi_if.slave));

    assign hi_if.ent = lo_if.rco;
    assign hi_if.enp = lo_if.enp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: what the counter holds after an edge, from the spec's priority rules.
    function automatic int ref_next(int cur, bit clr_n, bit load_n, bit enp, bit ent, int d);
        if (!clr_n)          return 0;
        else if (!load_n)    return d;
        else if (enp && ent) return (cur + 1) % 16;
        else                 return cur;
    endfunction

    task automatic drive(bit clr_n, bit load_n, bit enp, bit ent, logic [3:0] d);
        u_if.clr_n  = clr_n;
        u_if.load_n = load_n;
        u_if.enp    = enp;
        u_if.ent    = ent;
        u_if.d      = d;
    endtask

    // Apply the current inputs for one edge and update the model alongside.
    task automatic step();
        model = ref_next(model, u_if.clr_n, u_if.load_n, u_if.enp, u_if.ent, int'(u_if.d));
        tick();
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 1, 4'hA);
        tick();
        drive(1, 1, 0, 1, 4'h0);
        #2;
        checks++;
        if (u_if.q !== 4'hA) begin
            errors++;
            $display("FAIL reset_preload: q=%h expected %h", u_if.q, 4'hA);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (u_if.q !== 4'h0 || u_if.rco !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: q=%h rco=%b expected q=0 rco=0", u_if.q, u_if.rco);
        end
        #3;
        rst = 1'b0;
        model = 0;
        tick();
        checks++;
        if (u_if.q !== 4'h0) begin
            errors++;
            $display("FAIL reset_hold: q=%h expected 0", u_if.q);
        end
    endtask

    task automatic test_clear();
        drive(1, 0, 1, 1, 4'h5);
        step();
        drive(0, 1, 1, 1, 4'h0);
        step();
        checks++;
        if (u_if.q !== 4'(model) || model != 0) begin
            errors++;
            $display("FAIL sync_clear: q=%h expected 0", u_if.q);
        end
    endtask

    task automatic test_count_wrap();
        drive(1, 1, 1, 1, 4'h0);
        for (int i = 1; i <= 17; i++) begin
            step();
            checks++;
            if (u_if.q !== 4'(i % 16) || u_if.rco !== ((i % 16) == 15)) begin
                errors++;
                $display("FAIL count_wrap[%0d]: q=%h rco=%b expected q=%h rco=%b",
                         i, u_if.q, u_if.rco, i % 16, (i % 16) == 15);
            end
        end
        model = 1;
    endtask

    task automatic test_load();
        drive(1, 0, 1, 1, 4'b1010);
        step();
        checks++;
        if (u_if.q !== 4'hA) begin
            errors++;
            $display("FAIL load: q=%h expected a", u_if.q);
        end
        drive(1, 1, 1, 1, 4'b1010);
        step();
        checks++;
        if (u_if.q !== 4'hB) begin
            errors++;
            $display("FAIL load_then_count: q=%h expected b", u_if.q);
        end
    endtask

    task automatic test_priority();
        drive(0, 0, 1, 1, 4'hC);
        step();
        checks++;
        if (u_if.q !== 4'h0) begin
            errors++;
            $display("FAIL clear_over_load: q=%h expected 0", u_if.q);
        end
        drive(1, 0, 0, 0, 4'hF);
        step();
        drive(1, 1, 0, 1, 4'h0);
        step();
        checks++;
        if (u_if.q !== 4'hF || u_if.rco !== 1'b1) begin
            errors++;
            $display("FAIL enp_low_hold: q=%h rco=%b expected q=f rco=1", u_if.q, u_if.rco);
        end
        drive(1, 1, 1, 0, 4'h0);
        step();
        checks++;
        if (u_if.q !== 4'hF || u_if.rco !== 1'b0) begin
            errors++;
            $display("FAIL ent_low_hold: q=%h rco=%b expected q=f rco=0", u_if.q, u_if.rco);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 15) != 0), ($urandom_range(0, 5) != 0),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                  4'($urandom_range(0, 15)));
            step();
            checks++;
            if (u_if.q !== 4'(model) || u_if.rco !== (u_if.ent && model == 15)) begin
                errors++;
                $display("FAIL random[%0d]: q=%h rco=%b expected q=%h rco=%b",
                         i, u_if.q, u_if.rco, model, u_if.ent && model == 15);
            end
        end
    endtask

    task automatic test_cascade();
        lo_if.clr_n  = 1'b1;
        hi_if.clr_n  = 1'b1;
        lo_if.load_n = 1'b0;
        hi_if.load_n = 1'b0;
        lo_if.d      = 4'hE;
        hi_if.d      = 4'h0;
        lo_if.ent    = 1'b1;
        lo_if.enp    = 1'b1;
        tick();
        lo_if.load_n = 1'b1;
        hi_if.load_n = 1'b1;
        cmodel = 8'h0E;
        checks++;
        if ({hi_if.q, lo_if.q} !== 8'h0E) begin
            errors++;
            $display("FAIL cascade_load: q=%h expected 0e", {hi_if.q, lo_if.q});
        end
        for (int i = 1; i <= 242; i++) begin
            tick();
            cmodel = (cmodel + 1) % 256;
            checks++;
            if ({hi_if.q, lo_if.q} !== 8'(cmodel) || lo_if.rco !== ((cmodel % 16) == 15)) begin
                errors++;
                $display("FAIL cascade[%0d]: q=%h lo_rco=%b expected q=%h lo_rco=%b",
                         i, {hi_if.q, lo_if.q}, lo_if.rco, cmodel, (cmodel % 16) == 15);
            end
            if (i == 2) begin
                checks++;
                if ({hi_if.q, lo_if.q} !== 8'h10) begin
                    errors++;
                    $display("FAIL cascade_carry: q=%h expected 10", {hi_if.q, lo_if.q});
                end
            end
        end
        checks++;
        if ({hi_if.q, lo_if.q} !== 8'h00) begin
            errors++;
            $display("FAIL cascade_wrap: q=%h expected 00", {hi_if.q, lo_if.q});
        end
    endtask

    task automatic test_or_feed();
        logic [3:0] b;
        logic [3:0] y;
        b = 4'b0101;
        drive(1, 0, 1, 1, 4'b1010);
        step();
        y = u_if.q | b;
        checks++;
        if (y !== 4'b1111) begin
            errors++;
            $display("FAIL or_feed_a: y=%b expected 1111", y);
        end
        drive(1, 1, 1, 1, 4'h0);
        step();
        y = u_if.q | b;
        checks++;
        if (y !== 4'b1111) begin
            errors++;
            $display("FAIL or_feed_b: y=%b expected 1111", y);
        end
        for (int i = 0; i < 13; i++) step();
        y = u_if.q | b;
        checks++;
        if (u_if.q !== 4'h8 || y !== 4'b1101) begin
            errors++;
            $display("FAIL or_feed_8: q=%h y=%b expected q=8 y=1101", u_if.q, y);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model  = 0;
        cmodel = 0;
        rst    = 1'b1;
        drive(1, 1, 0, 0, 4'h0);
        lo_if.clr_n  = 1'b1;
        lo_if.load_n = 1'b1;
        lo_if.enp    = 1'b0;
        lo_if.ent    = 1'b0;
        lo_if.d      = 4'h0;
        hi_if.clr_n  = 1'b1;
        hi_if.load_n = 1'b1;
        hi_if.d      = 4'h0;
        #12;
        rst = 1'b0;
        checks++;
        if (u_if.q !== 4'h0 || u_if.rco !== 1'b0) begin
            errors++;
            $display("FAIL power_on_reset: q=%h rco=%b expected q=0 rco=0", u_if.q, u_if.rco);
        end
        tick();
        test_reset();
        test_clear();
        test_count_wrap();
        test_load();
        test_priority();
        test_random();
        test_cascade();
        test_or_feed();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
